// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcode encoding, flag register layout and the
// opcode-class helpers also used by the hazard unit.
package wisc_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LHB    = 4'hA,
        OP_LLB    = 4'hB,
        OP_B      = 4'hC,
        OP_BR     = 4'hD,
        OP_PCS    = 4'hE,
        OP_HLT    = 4'hF
    } opcode_t;

    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flag_t;

    function automatic logic sets_all_flags(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic sets_z_only(input opcode_t op);
        return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/flag_unit.sv
// Architectural Z/V/N flag register; also exposes the value it will load
// at the next edge so the stage can bypass it to decode.
module flag_unit
    import wisc_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  opcode_t       opcode,
    input  logic [DW-1:0] result,
    input  logic          ovfl,
    input  logic          update,
    output flag_t         flags,
    output flag_t         flags_next
);

    always_comb begin
        flags_next = flags;
        if (update) begin
            if (sets_all_flags(opcode)) begin
                flags_next.z = (result == '0);
                flags_next.v = ovfl;
                flags_next.n = result[DW-1];
            end else if (sets_z_only(opcode)) begin
                flags_next.z = (result == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= '0;
        end else begin
            flags <= flags_next;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with stall/flush handling, sticky halt and flags.
// Define FLAG_BYPASS_EN to drive the flag outputs with the next-edge value.
module ex_mem_stage
    import wisc_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          ex_valid,
    input  logic [3:0]    ex_opcode,
    input  logic [DW-1:0] ex_result,
    input  logic          ex_ovfl,
    input  logic [DW-1:0] ex_store_data,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_reg_wen,
    input  logic          ex_mem_wen,
    input  logic          ex_mem_ren,
    input  logic          ex_halt,
    output logic          mem_valid,
    output logic [DW-1:0] mem_result,
    output logic [DW-1:0] mem_store_data,
    output logic [RW-1:0] mem_rd,
    output logic          mem_reg_wen,
    output logic          mem_mem_wen,
    output logic          mem_mem_ren,
    output logic          flag_z,
    output logic          flag_v,
    output logic          flag_n,
    output logic          halted
);

`ifdef FLAG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          valid_q;
    logic [DW-1:0] result_q;
    logic [DW-1:0] store_q;
    logic [RW-1:0] rd_q;
    logic          reg_wen_q;
    logic          mem_wen_q;
    logic          mem_ren_q;
    logic          halted_q;
    logic          flush_pending;
    logic          flag_update;
    flag_t         flags_q;
    flag_t         flags_next;
    flag_t         flag_out;

    // A pending flush counts exactly like a live one on the first free edge.
    assign flag_update = ex_valid && !stall && !flush && !flush_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= 1'b0;
            result_q      <= '0;
            store_q       <= '0;
            rd_q          <= '0;
            reg_wen_q     <= 1'b0;
            mem_wen_q     <= 1'b0;
            mem_ren_q     <= 1'b0;
            halted_q      <= 1'b0;
            flush_pending <= 1'b0;
        end else if (stall) begin
            if (flush) begin
                flush_pending <= 1'b1;
            end
        end else if (flush || flush_pending) begin
            valid_q       <= 1'b0;
            reg_wen_q     <= 1'b0;
            mem_wen_q     <= 1'b0;
            mem_ren_q     <= 1'b0;
            flush_pending <= 1'b0;
        end else begin
            valid_q   <= ex_valid;
            result_q  <= ex_result;
            store_q   <= ex_store_data;
            rd_q      <= ex_rd;
            reg_wen_q <= ex_reg_wen && !halted_q;
            mem_wen_q <= ex_mem_wen && !halted_q;
            mem_ren_q <= ex_mem_ren;
            if (ex_valid && ex_halt) begin
                halted_q <= 1'b1;
            end
        end
    end

    flag_unit #(
        .DW(DW)
    ) u_flag_unit (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode_t'(ex_opcode)),
        .result    (ex_result),
        .ovfl      (ex_ovfl),
        .update    (flag_update),
        .flags     (flags_q),
        .flags_next(flags_next)
    );

    assign flag_out       = BYPASS ? flags_next : flags_q;
    assign flag_z         = flag_out.z;
    assign flag_v         = flag_out.v;
    assign flag_n         = flag_out.n;

    assign mem_valid      = valid_q;
    assign mem_result     = result_q;
    assign mem_store_data = store_q;
    assign mem_rd         = rd_q;
    assign mem_reg_wen    = valid_q && reg_wen_q;
    assign mem_mem_wen    = valid_q && mem_wen_q;
    assign mem_mem_ren    = valid_q && mem_ren_q;
    assign halted         = halted_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed scoreboard bench for ex_mem_stage: expectations are queued per
// edge and checked one cycle later against the registered outputs.
module tb_ex_mem_stage;
    import wisc_pkg::*;

    localparam int DW = 16;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst, stall, flush;
    logic          ex_valid, ex_ovfl, ex_reg_wen, ex_mem_wen, ex_mem_ren, ex_halt;
    logic [3:0]    ex_opcode;
    logic [DW-1:0] ex_result, ex_store_data;
    logic [RW-1:0] ex_rd;
    logic          mem_valid, mem_reg_wen, mem_mem_wen, mem_mem_ren;
    logic [DW-1:0] mem_result, mem_store_data;
    logic [RW-1:0] mem_rd;
    logic          flag_z, flag_v, flag_n, halted;

    typedef struct {
        logic        valid;
        logic [15:0] result;
        logic [15:0] store;
        logic [3:0]  rd;
        logic        reg_wen, mem_wen, mem_ren;
        logic        z, v, n, halted;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(
        .DW(DW),
        .RW(RW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_opcode     (ex_opcode),
        .ex_result     (ex_result),
        .ex_ovfl       (ex_ovfl),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_reg_wen    (ex_reg_wen),
        .ex_mem_wen    (ex_mem_wen),
        .ex_mem_ren    (ex_mem_ren),
        .ex_halt       (ex_halt),
        .mem_valid     (mem_valid),
        .mem_result    (mem_result),
        .mem_store_data(mem_store_data),
        .mem_rd        (mem_rd),
        .mem_reg_wen   (mem_reg_wen),
        .mem_mem_wen   (mem_mem_wen),
        .mem_mem_ren   (mem_mem_ren),
        .flag_z        (flag_z),
        .flag_v        (flag_v),
        .flag_n        (flag_n),
        .halted        (halted)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic [15:0] res, input logic [15:0] sd,
                                input logic [3:0] rd, input logic rw, input logic mw,
                                input logic mr, input logic z, input logic vf,
                                input logic n, input logic h);
        exp_t e;
        e.valid = v; e.result = res; e.store = sd; e.rd = rd;
        e.reg_wen = rw; e.mem_wen = mw; e.mem_ren = mr;
        e.z = z; e.v = vf; e.n = n; e.halted = h;
        return e;
    endfunction

    task automatic drive(input logic v, input opcode_t op, input logic [15:0] res,
                         input logic ovfl, input logic [15:0] sd, input logic [3:0] rd,
                         input logic rw, input logic mw, input logic mr, input logic h);
        ex_valid = v; ex_opcode = op; ex_result = res; ex_ovfl = ovfl;
        ex_store_data = sd; ex_rd = rd; ex_reg_wen = rw; ex_mem_wen = mw;
        ex_mem_ren = mr; ex_halt = h;
    endtask

    task automatic idle();
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b0, OP_ADD, 16'h0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Queue the expectation, clock one edge, quiesce inputs, then compare.
    task automatic tick(input string tag, input exp_t e);
        exp_t g;
        sb.push_back(e);
        @(posedge clk);
        #1;
        idle();
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 16'd1, 16'd0);
        end else begin
            g = sb.pop_front();
            chk({tag, ".valid"}, mem_valid, g.valid);
            if (g.valid) begin
                chk({tag, ".result"}, mem_result, g.result);
                chk({tag, ".store"}, mem_store_data, g.store);
                chk({tag, ".rd"}, mem_rd, g.rd);
            end
            chk({tag, ".reg_wen"}, mem_reg_wen, g.reg_wen);
            chk({tag, ".mem_wen"}, mem_mem_wen, g.mem_wen);
            chk({tag, ".mem_ren"}, mem_mem_ren, g.mem_ren);
            chk({tag, ".flags"}, {flag_z, flag_v, flag_n}, {g.z, g.v, g.n});
            chk({tag, ".halted"}, halted, g.halted);
        end
    endtask

    initial begin
        exp_t held;
        idle();
        @(negedge clk);

        rst = 1'b1;
        tick("reset", mk(0, 16'h0, 16'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0));

        drive(1, OP_ADD, 16'h0000, 1, 16'h1111, 4'd3, 1, 0, 0, 0);
        tick("add_zero_ovfl", mk(1, 16'h0000, 16'h1111, 4'd3, 1, 0, 0, 1, 1, 0, 0));
        drive(1, OP_XOR, 16'h8000, 0, 16'h0, 4'd4, 1, 0, 0, 0);
        tick("xor_z_only", mk(1, 16'h8000, 16'h0, 4'd4, 1, 0, 0, 0, 1, 0, 0));
        drive(1, OP_SUB, 16'h8001, 0, 16'h0, 4'd5, 1, 0, 0, 0);
        tick("sub_neg", mk(1, 16'h8001, 16'h0, 4'd5, 1, 0, 0, 0, 0, 1, 0));
        drive(1, OP_PADDSB, 16'h7878, 1, 16'h0, 4'd6, 1, 0, 0, 0);
        tick("paddsb", mk(1, 16'h7878, 16'h0, 4'd6, 1, 0, 0, 0, 0, 1, 0));
        drive(1, OP_SW, 16'h0000, 1, 16'hABCD, 4'd7, 0, 1, 0, 0);
        tick("sw", mk(1, 16'h0000, 16'hABCD, 4'd7, 0, 1, 0, 0, 0, 1, 0));
        drive(1, OP_LW, 16'h0000, 0, 16'h0, 4'd8, 1, 0, 1, 0);
        tick("lw", mk(1, 16'h0000, 16'h0, 4'd8, 1, 0, 1, 0, 0, 1, 0));
        drive(0, OP_ADD, 16'h0000, 1, 16'h0, 4'd9, 1, 1, 1, 1);
        tick("invalid", mk(0, 16'h0, 16'h0, 4'd0, 0, 0, 0, 0, 0, 1, 0));
        drive(1, OP_SLL, 16'h0000, 0, 16'h0, 4'd9, 1, 0, 0, 0);
        tick("sll_zero", mk(1, 16'h0000, 16'h0, 4'd9, 1, 0, 0, 1, 0, 1, 0));
        drive(1, OP_ADD, 16'h1234, 0, 16'h0, 4'd2, 1, 0, 0, 0);
        held = mk(1, 16'h1234, 16'h0, 4'd2, 1, 0, 0, 0, 0, 0, 0);
        tick("add_pos", held);

        // Three stalled cycles with flush pulsed in the middle one.
        stall = 1; drive(1, OP_ADD, 16'h0000, 1, 16'h0, 4'd1, 1, 0, 0, 0);
        tick("stall1", held);
        stall = 1; flush = 1; drive(1, OP_ADD, 16'h0000, 1, 16'h0, 4'd1, 1, 0, 0, 0);
        tick("stall2_flush", held);
        stall = 1; drive(1, OP_ADD, 16'h0000, 1, 16'h0, 4'd1, 1, 0, 0, 0);
        tick("stall3", held);
        drive(1, OP_ADD, 16'h0000, 1, 16'h0, 4'd1, 1, 0, 0, 0);
        tick("pending_bubble", mk(0, 16'h0, 16'h0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
        drive(1, OP_ROR, 16'h0000, 0, 16'h0, 4'd10, 1, 0, 0, 0);
        tick("after_bubble", mk(1, 16'h0000, 16'h0, 4'd10, 1, 0, 0, 1, 0, 0, 0));

        flush = 1; drive(1, OP_SUB, 16'h0000, 1, 16'h0, 4'd1, 1, 0, 0, 0);
        tick("flush", mk(0, 16'h0, 16'h0, 4'd0, 0, 0, 0, 1, 0, 0, 0));
        stall = 1; flush = 1; drive(1, OP_ADD, 16'h0000, 1, 16'h0, 4'd1, 1, 0, 0, 0);
        tick("stall_flush", mk(0, 16'h0, 16'h0, 4'd0, 0, 0, 0, 1, 0, 0, 0));
        drive(1, OP_SUB, 16'h0000, 1, 16'h0, 4'd1, 1, 1, 0, 0);
        tick("deassert_same", mk(0, 16'h0, 16'h0, 4'd0, 0, 0, 0, 1, 0, 0, 0));
        drive(1, OP_SUB, 16'h0000, 1, 16'h0, 4'd11, 1, 0, 0, 0);
        tick("sub_zero", mk(1, 16'h0000, 16'h0, 4'd11, 1, 0, 0, 1, 1, 0, 0));

        drive(1, OP_HLT, 16'h0000, 0, 16'h0, 4'd0, 0, 0, 0, 1);
        tick("hlt", mk(1, 16'h0000, 16'h0, 4'd0, 0, 0, 0, 1, 1, 0, 1));
        drive(1, OP_ADD, 16'h0005, 0, 16'h0, 4'd12, 1, 0, 0, 0);
        tick("halted_add", mk(1, 16'h0005, 16'h0, 4'd12, 0, 0, 0, 0, 0, 0, 1));
        drive(1, OP_SW, 16'h0000, 0, 16'h5555, 4'd0, 0, 1, 0, 0);
        tick("halted_sw", mk(1, 16'h0000, 16'h5555, 4'd0, 0, 0, 0, 0, 0, 0, 1));
        drive(1, OP_LW, 16'h0000, 0, 16'h0, 4'd13, 1, 0, 1, 0);
        tick("halted_lw", mk(1, 16'h0000, 16'h0, 4'd13, 0, 0, 1, 0, 0, 0, 1));
        flush = 1; drive(1, OP_ADD, 16'h0000, 1, 16'h0, 4'd1, 1, 0, 0, 0);
        tick("halted_bubble", mk(0, 16'h0, 16'h0, 4'd0, 0, 0, 0, 0, 0, 0, 1));
        rst = 1;
        tick("rst_halt", mk(0, 16'h0, 16'h0, 4'd0, 0, 0, 0, 0, 0, 0, 0));

        drive(1, OP_ADD, 16'h8000, 1, 16'h0, 4'd14, 1, 0, 0, 0);
        held = mk(1, 16'h8000, 16'h0, 4'd14, 1, 0, 0, 0, 1, 1, 0);
        tick("add_neg_ovfl", held);
        stall = 1; flush = 1;
        tick("stall_flush2", held);
        rst = 1; stall = 1;
        tick("rst_mid_stall", mk(0, 16'h0, 16'h0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
        drive(1, OP_XOR, 16'h0000, 0, 16'h0, 4'd15, 1, 0, 0, 0);
        tick("pending_cleared", mk(1, 16'h0000, 16'h0, 4'd15, 1, 0, 0, 1, 0, 0, 0));
        drive(1, OP_ADD, 16'h0001, 0, 16'h0, 4'd1, 1, 0, 0, 0);
        tick("add_one", mk(1, 16'h0001, 16'h0, 4'd1, 1, 0, 0, 0, 0, 0, 0));

`ifdef FLAG_BYPASS_EN
        drive(1, OP_SUB, 16'h0000, 0, 16'h0, 4'd2, 1, 0, 0, 0);
        #1;
        chk("bypass_z", flag_z, 1'b1);
        stall = 1;
        #1;
        chk("bypass_stalled_z", flag_z, 1'b0);
        idle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
